// File: rtl/seg_display_mux_if.sv
// Bus between the status encoder and the 3-digit 7-segment multiplexer.
// There is no valid/ready pair. The display samples digits_in once per frame, on the first edge of digit 0, and ignores it at every other edge.
interface seg_display_mux_if;
  logic [11:0] digits_in;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  an;
  logic        frame_tick;
  logic        dbg_show;

  modport master (output digits_in, input seg, dp, an, frame_tick, dbg_show);
  modport slave  (input digits_in, output seg, dp, an, frame_tick, dbg_show);
endinterface

// File: rtl/seg_display_mux.sv
// Multiplexed 3-digit hex 7-segment driver with per-slot anti-ghost blanking and a once-per-frame input latch.
// Optional feature: define SEG_HEARTBEAT_EN to blink the digit-0 decimal point every 128 frames.
module seg_display_mux #(
  parameter int DIGIT_CYCLES   = 100000,
  parameter int BLANK_CYCLES   = 2000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  seg_display_mux_if.slave bus
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST       = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] CYC_BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [6:0]    SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic          DP_OFF  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [2:0]    AN_OFF  = AN_ACTIVE_LOW ? 3'b111 : 3'b000;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [1:0]  digit_q, digit_d;
  logic [11:0] shadow_q, shadow_d;
  logic [2:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        ft_q, ft_d;
  logic [3:0]  nibble;
  logic [2:0]  onehot;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

`ifdef SEG_HEARTBEAT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 8'd0;
    end else if (ft_q) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end
`endif

  always_comb begin
    cyc_d   = cyc_q + CW'(1);
    digit_d = digit_q;
    state_d = state_q;
    if (cyc_q == CYC_LAST) begin
      cyc_d   = '0;
      digit_d = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
    end

    case (state_q)
      ST_BLANK: if (cyc_q == CYC_BLANK_LAST) state_d = ST_SHOW;
      ST_SHOW:  if (cyc_q == CYC_LAST)       state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase

    // Decode from the value being latched this edge, so digit 0 never shows the previous frame's nibble.
    shadow_d = (cyc_q == '0 && digit_q == 2'd0) ? bus.digits_in : shadow_q;
    case (digit_q)
      2'd0:    nibble = shadow_d[3:0];
      2'd1:    nibble = shadow_d[7:4];
      default: nibble = shadow_d[11:8];
    endcase

    onehot = 3'b001 << digit_q;
    an_d   = AN_OFF;
    seg_d  = seg_q;
    if (state_q == ST_SHOW) begin
      an_d = AN_ACTIVE_LOW ? ~onehot : onehot;
    end else begin
      seg_d = SEG_ACTIVE_LOW ? ~hex_to_seg(nibble) : hex_to_seg(nibble);
    end

    ft_d = (digit_d == 2'd2) && (cyc_d == CYC_LAST);

    dp_d = DP_OFF;
`ifdef SEG_HEARTBEAT_EN
    if (state_q == ST_SHOW && digit_q == 2'd0 && frame_cnt_q[7]) dp_d = ~DP_OFF;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q    <= '0;
      digit_q  <= 2'd0;
      state_q  <= ST_BLANK;
      shadow_q <= 12'h000;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      dp_q     <= DP_OFF;
      ft_q     <= 1'b0;
    end else begin
      cyc_q    <= cyc_d;
      digit_q  <= digit_d;
      state_q  <= state_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      ft_q     <= ft_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = ft_q;
  assign bus.dbg_show   = (state_q == ST_SHOW);

endmodule

// File: tb/tb_seg_display_mux.sv
// Frame-level bench for seg_display_mux with 8-cycle slots and 2 blank cycles.
module tb_seg_display_mux;
  localparam int DC = 8;
  localparam int BC = 2;
  localparam int FRAME = 3 * DC;

  // Clock/reset block
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_display_mux_if bus();

  seg_display_mux #(
    .DIGIT_CYCLES(DC),
    .BLANK_CYCLES(BC),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [11:0] din;
    logic [11:0] din_mid;
    int          mid_at;
    logic [11:0] shown;
  } vec_t;

  logic [6:0] hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Packed as {an, seg, dp, frame_tick, dbg_show}
  localparam logic [12:0] INACTIVE = {3'b111, 7'h7F, 1'b1, 1'b0, 1'b0};

  logic [12:0] exp_q[$];
  vec_t        vecs [22];
  int          errors = 0;
  int          checks = 0;
  int          f_abs  = 0;

  function automatic logic [12:0] expect_at(input logic [11:0] shown, input int k, input int frames);
    int slot;
    int c;
    logic [2:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
    logic       show;
    slot = k / DC;
    c    = k % DC;
    an   = (c >= BC) ? ~(3'b001 << slot) : 3'b111;
    seg  = ~hex7[shown[slot*4 +: 4]];
    ft   = (k == FRAME - 2);
    show = (((k + 1) % DC) >= BC);
`ifdef SEG_HEARTBEAT_EN
    dp   = !(slot == 0 && c >= BC && frames[7]);
`else
    dp   = 1'b1 | frames[0];
`endif
    return {an, seg, dp, ft, show};
  endfunction

  function automatic logic [12:0] dut_out();
    return {bus.an, bus.seg, bus.dp, bus.frame_tick, bus.dbg_show};
  endfunction

  // Scoreboard
  task automatic check(input string name, input logic [12:0] exp, input logic [12:0] act);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got an=%b seg=%h dp=%b tick=%b show=%b, expected an=%b seg=%h dp=%b tick=%b show=%b",
               name, act[12:10], act[9:3], act[2], act[1], act[0],
               exp[12:10], exp[9:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic pop_check(input string name);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got an=%b seg=%h", name, bus.an, bus.seg);
    end else begin
      check(name, exp_q.pop_front(), dut_out());
    end
  endtask

  // Driver: one frame, optionally stopping before frame cycle stop_at
  task automatic run_frame(input vec_t v, input int stop_at);
    for (int k = 0; k < FRAME; k++) begin
      if (k == stop_at) return;
      if (k == 0) bus.digits_in = v.din;
      else if (k == v.mid_at) bus.digits_in = v.din_mid;
      exp_q.push_back(expect_at(v.shown, k, f_abs));
      @(posedge clk);
      #1;
      pop_check($sformatf("f%0d_k%0d", f_abs, k));
    end
    f_abs++;
  endtask

  initial begin
    vecs[0] = '{12'hA5F, 12'hA5F, -1, 12'hA5F};
    for (int i = 0; i < 16; i++) begin
      logic [11:0] d;
      d = {4'(15 - i), 4'(i ^ 5), 4'(i)};
      vecs[1 + i] = '{d, d, -1, d};
    end
    vecs[17] = '{12'h123, 12'h456, 10, 12'h123};
    vecs[18] = '{12'h456, 12'h456, -1, 12'h456};
    vecs[19] = '{12'h3B8, 12'h3B8, -1, 12'h3B8};
    vecs[20] = '{12'h7E9, 12'hD0C, 23, 12'h7E9};
    vecs[21] = '{12'hD0C, 12'hD0C, -1, 12'hD0C};

    rst_n = 1'b0;
    bus.digits_in = 12'hA5F;
    repeat (2) @(posedge clk);
    #1 check("reset_state", INACTIVE, dut_out());
    @(negedge clk);
    check("reset_hold", INACTIVE, dut_out());
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      run_frame(vecs[i], (i == 19) ? 13 : -1);
    end

    // Reset lands while digit 1 is being shown
    check("pre_reset_digit1", {3'b101, ~hex7[4'hB], 1'b1, 1'b0, 1'b1}, dut_out());
    #2 rst_n = 1'b0;
    #1 check("async_reset", INACTIVE, dut_out());
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 check($sformatf("reset_held_%0d", i), INACTIVE, dut_out());
    end
    @(negedge clk);
    rst_n = 1'b1;
    f_abs = 0;
    run_frame(vecs[20], -1);
    run_frame(vecs[21], -1);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
